// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues one request at a time on the
// req/gnt/rvalid instruction port, and presents one instruction at a time to IF/ID.
//
// state | meaning
// ------+--------------------------------------------------------------
// REQ   | request pc on imem; no access outstanding
// WAIT  | request granted, waiting for imem_rvalid
// HOLD  | response parked in skid because IF/ID was stalled
// DRAIN | redirected while a request was outstanding; drop its response
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        fetch_valid,
    output logic [31:0] fetch_pc,
    output logic [31:0] fetch_instr
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DRAIN} state_t;

    state_t      state, state_nx;
    logic [31:0] pc, pc_nx;
    logic [31:0] skid_pc, skid_pc_nx;
    logic [31:0] skid_instr, skid_instr_nx;
    logic        fetch_valid_nx;
    logic [31:0] fetch_pc_nx;
    logic [31:0] fetch_instr_nx;
    logic        slot_free;
    logic        unused_redirect_lsb;

    // Targets are word aligned; the low address bits carry no information.
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    assign slot_free = !fetch_valid || !pc_stall;
    assign imem_req  = (state == S_REQ) && !redirect_valid;
    assign imem_addr = pc;

    always_comb begin
        state_nx       = state;
        pc_nx          = pc;
        skid_pc_nx     = skid_pc;
        skid_instr_nx  = skid_instr;
        fetch_valid_nx = fetch_valid;
        fetch_pc_nx    = fetch_pc;
        fetch_instr_nx = fetch_instr;

        if (slot_free) begin
            fetch_valid_nx = 1'b0;
            fetch_instr_nx = NOP_INSTR;
        end

        if (redirect_valid) begin
            pc_nx          = {redirect_pc[31:2], 2'b00};
            fetch_valid_nx = 1'b0;
            fetch_instr_nx = NOP_INSTR;
            skid_pc_nx     = '0;
            skid_instr_nx  = '0;
            if ((state == S_WAIT || state == S_DRAIN) && !imem_rvalid)
                state_nx = S_DRAIN;
            else
                state_nx = S_REQ;
        end else begin
            case (state)
                S_REQ: begin
                    if (imem_gnt && imem_req)
                        state_nx = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        pc_nx = pc + 32'd4;
                        if (slot_free) begin
                            fetch_valid_nx = 1'b1;
                            fetch_pc_nx    = pc;
                            fetch_instr_nx = imem_rdata;
                            state_nx       = S_REQ;
                        end else begin
                            skid_pc_nx    = pc;
                            skid_instr_nx = imem_rdata;
                            state_nx      = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (slot_free) begin
                        fetch_valid_nx = 1'b1;
                        fetch_pc_nx    = skid_pc;
                        fetch_instr_nx = skid_instr;
                        state_nx       = S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (imem_rvalid)
                        state_nx = S_REQ;
                end
                default: state_nx = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_REQ;
            pc          <= RESET_PC;
            skid_pc     <= '0;
            skid_instr  <= '0;
            fetch_valid <= 1'b0;
            fetch_pc    <= '0;
            fetch_instr <= NOP_INSTR;
        end else begin
            state       <= state_nx;
            pc          <= pc_nx;
            skid_pc     <= skid_pc_nx;
            skid_instr  <= skid_instr_nx;
            fetch_valid <= fetch_valid_nx;
            fetch_pc    <= fetch_pc_nx;
            fetch_instr <= fetch_instr_nx;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed stimulus against a latency-programmable memory,
// a transaction-level reference model compared every cycle, plus literal spot checks.
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pc_stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_instr;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;
    int lat = 1;
    int cyc = 0;

    if_fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_stall       (pc_stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .fetch_valid    (fetch_valid),
        .fetch_pc       (fetch_pc),
        .fetch_instr    (fetch_instr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h4) ? 32'hDEAD_BEEF : (a ^ 32'h1357_9BDF);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, got, exp, $time);
        end
    endtask

    // Memory: accepted requests answered in order, lat cycles after the grant.
    typedef struct {logic [31:0] addr; int due;} mreq_t;
    mreq_t mq[$];

    initial forever begin
        @(posedge clk);
        if (rst_n && imem_req && imem_gnt)
            mq.push_back('{addr: imem_addr, due: cyc + lat});
        cyc++;
        #2;
        if (mq.size() > 0 && mq[0].due == cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
    end

    // Reference model: tracks an outstanding access, a pending-discard flag and a
    // buffer of at most one fetched-but-unpresented instruction.
    typedef struct packed {logic [31:0] pc; logic [31:0] instr;} ent_t;
    ent_t        m_buf[$];
    logic [31:0] m_pc = 32'h0;
    bit          m_valid = 1'b0;
    logic [31:0] m_out_pc = 32'h0;
    logic [31:0] m_out_instr = NOP;
    bit          m_outst = 1'b0;
    bit          m_disc = 1'b0;

    task automatic model_reset();
        m_buf.delete();
        m_pc = 32'h0; m_valid = 1'b0; m_out_pc = 32'h0; m_out_instr = NOP;
        m_outst = 1'b0; m_disc = 1'b0;
    endtask

    task automatic model_step();
        bit          sf;
        bit          idle;
        bit          got;
        ent_t        e;
        sf   = !m_valid || !pc_stall;
        idle = !m_outst && (m_buf.size() == 0);
        got  = 1'b0;
        e    = '0;
        if (redirect_valid) begin
            m_valid = 1'b0;
            m_out_instr = NOP;
            m_buf.delete();
            if (m_outst && !imem_rvalid) m_disc = 1'b1;
            else begin m_outst = 1'b0; m_disc = 1'b0; end
            m_pc = {redirect_pc[31:2], 2'b00};
        end else begin
            if (m_outst && imem_rvalid) begin
                m_outst = 1'b0;
                if (m_disc) m_disc = 1'b0;
                else begin
                    got = 1'b1; e.pc = m_pc; e.instr = imem_rdata;
                    m_pc = m_pc + 32'd4;
                end
            end else if (m_buf.size() > 0 && sf) begin
                got = 1'b1; e = m_buf.pop_front();
            end
            if (sf) begin
                if (got) begin m_valid = 1'b1; m_out_pc = e.pc; m_out_instr = e.instr; end
                else begin m_valid = 1'b0; m_out_instr = NOP; end
            end else if (got) begin
                m_buf.push_back(e);
            end
            if (idle && imem_gnt) m_outst = 1'b1;
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) model_reset();
        else model_step();
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_imem_req", {31'b0, imem_req},
                {31'b0, !m_outst && (m_buf.size() == 0) && !redirect_valid});
            chk("m_imem_addr", imem_addr, m_pc);
            chk("m_fetch_valid", {31'b0, fetch_valid}, {31'b0, m_valid});
            chk("m_fetch_pc", fetch_pc, m_out_pc);
            chk("m_fetch_instr", fetch_instr, m_out_instr);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic lit_out(input string name, input bit v, input logic [31:0] p, input logic [31:0] ins);
        chk({name, "_valid"}, {31'b0, fetch_valid}, {31'b0, v});
        chk({name, "_pc"}, fetch_pc, p);
        chk({name, "_instr"}, fetch_instr, ins);
    endtask

    task automatic lit_req(input string name, input bit r, input logic [31:0] a);
        chk({name, "_req"}, {31'b0, imem_req}, {31'b0, r});
        chk({name, "_addr"}, imem_addr, a);
    endtask

    initial begin
        rst_n = 1'b0; pc_stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; imem_gnt = 1'b1;
        tick(); tick();
        #1 lit_out("rst", 1'b0, 32'h0, NOP);
        lit_req("rst", 1'b1, 32'h0);
        chk_en = 1'b1;

        // Back-to-back fetches with 1-cycle memory
        tick(); rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1 lit_req("t1_issue", 1'b1, 32'(4 * k));
            tick(); #1 chk("t1_wait_req", {31'b0, imem_req}, 32'h0);
            chk("t1_gap_valid", {31'b0, fetch_valid}, 32'h0);
            tick(); #1 lit_out("t1_out", 1'b1, 32'(4 * k), mem_word(32'(4 * k)));
        end

        // Stall while a response arrives: skid, then present after release
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        #1 chk("t2_redir_req", {31'b0, imem_req}, 32'h0);
        tick(); redirect_valid = 1'b0;
        #1 lit_out("t2_after_redir", 1'b0, 32'h8, NOP);
        lit_req("t2_r1", 1'b1, 32'h0);
        tick();
        tick(); pc_stall = 1'b1;
        #1 lit_out("t2_first", 1'b1, 32'h0, mem_word(32'h0));
        tick();
        tick(); #1 lit_out("t2_hold1", 1'b1, 32'h0, mem_word(32'h0));
        chk("t2_hold1_req", {31'b0, imem_req}, 32'h0);
        tick(); #1 lit_out("t2_hold2", 1'b1, 32'h0, mem_word(32'h0));
        tick(); pc_stall = 1'b0;
        #1 lit_out("t2_hold3", 1'b1, 32'h0, mem_word(32'h0));
        tick(); lat = 2;
        #1 lit_out("t2_release", 1'b1, 32'h4, 32'hDEAD_BEEF);
        lit_req("t2_next", 1'b1, 32'h8);

        // Redirect during WAIT; late response must be dropped
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h100;
        #1 chk("t3_wait_valid", {31'b0, fetch_valid}, 32'h0);
        tick(); redirect_valid = 1'b0;
        #1 lit_req("t3_drain", 1'b0, 32'h100);
        chk("t3_drain_valid", {31'b0, fetch_valid}, 32'h0);
        tick(); #1 lit_req("t3_issue", 1'b1, 32'h100);
        chk("t3_drop_valid", {31'b0, fetch_valid}, 32'h0);
        tick(); lat = 1;
        tick();
        tick(); #1 lit_out("t3_out", 1'b1, 32'h100, mem_word(32'h100));

        // Redirect coinciding with rvalid
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h200;
        tick(); redirect_valid = 1'b0;
        #1 lit_out("t4_after", 1'b0, 32'h100, NOP);
        lit_req("t4_issue", 1'b1, 32'h200);
        tick();
        tick(); #1 lit_out("t4_out", 1'b1, 32'h200, mem_word(32'h200));

        // Redirect overrides stall; low bits dropped; PC wraps
        pc_stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h1002;
        tick(); redirect_valid = 1'b0;
        #1 chk("t5_stall_redir_valid", {31'b0, fetch_valid}, 32'h0);
        lit_req("t5_align", 1'b1, 32'h1000);
        tick(); pc_stall = 1'b0;
        tick(); #1 lit_out("t5_out", 1'b1, 32'h1000, mem_word(32'h1000));
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick(); redirect_valid = 1'b0;
        #1 lit_req("t5_top", 1'b1, 32'hFFFF_FFFC);
        tick();
        tick(); #1 lit_out("t5_top_out", 1'b1, 32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC));
        lit_req("t5_wrap", 1'b1, 32'h0);
        imem_gnt = 1'b0;

        // Async reset mid-WAIT; stale response ignored
        tick(); imem_gnt = 1'b1; lat = 3;
        #1 lit_req("t6_retry", 1'b1, 32'h0);
        tick(); rst_n = 1'b0;
        #1 lit_out("t6_async", 1'b0, 32'h0, NOP);
        lit_req("t6_async", 1'b1, 32'h0);
        tick(); rst_n = 1'b1; imem_gnt = 1'b0; lat = 1;
        tick(); imem_gnt = 1'b1;
        #1 chk("t6_stale_rvalid", {31'b0, imem_rvalid}, 32'h1);
        lit_req("t6_first", 1'b1, 32'h0);
        tick(); #1 chk("t6_stale_dropped", {31'b0, fetch_valid}, 32'h0);
        tick(); #1 lit_out("t6_out", 1'b1, 32'h0, mem_word(32'h0));
        lit_req("t6_next", 1'b1, 32'h4);
        tick(); tick();
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
